fxp_requant: RTL and testbench

//  Converts a dynamic-format fixed-point word, as produced by the FXP adder
//  (data + QI/QF tags), back into a caller-chosen fixed Q format.

---
 rtl/fxp_requant.sv | 215 +++++++++++++++++++++
 tb/tb_fxp_requant.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_requant.sv
// -----------------------------------------------------------------------------
// fxp_requant
//
// Purpose:
//   Converts a dynamic-format fixed-point word (data plus QI/QF tags, as
//   produced by the FXP adder) into a caller-chosen fixed Q format. The
//   realignment is done by an iterative shifter, one bit per clock, with
//   valid/ready handshakes on both sides. Overflow on left shifts saturates
//   and is flagged; an illegal format passes the data through unchanged and
//   raises out_err.
//
// Build option:
//   FXP_RQ_ROUND_EN  defined   -> right shifts round half-up (the last bit
//                                 shifted out is added on entering DONE;
//                                 overflow of that add saturates).
//                    undefined -> right shifts truncate toward -inf.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   in_valid   in   1  input word available
//   in_ready   out  1  block can accept (IDLE only)
//   in_data    in   W  signed input word
//   in_qi      in   4  input integer bits (incl. sign)
//   in_qf      in   4  input fraction bits
//   tgt_qi     in   4  target integer bits, sampled with the input
//   tgt_qf     in   4  target fraction bits, sampled with the input
//   out_valid  out  1  result available, held until out_ready
//   out_ready  in   1  downstream accepts result
//   out_data   out  W  signed result in target format
//   out_qi     out  4  latched tgt_qi
//   out_qf     out  4  latched tgt_qf
//   out_sat    out  1  result was saturated
//   out_err    out  1  illegal format; out_data = input unchanged
// -----------------------------------------------------------------------------
module fxp_requant #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic [3:0]           in_qi,
    input  logic [3:0]           in_qf,
    input  logic [3:0]           tgt_qi,
    input  logic [3:0]           tgt_qf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic [3:0]           out_qi,
    output logic [3:0]           out_qf,
    output logic                 out_sat,
    output logic                 out_err
);

    localparam int W = WORD_SIZE;
    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [4:0]   W5      = 5'(W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   data_q,  data_d;
    logic [3:0]     cnt_q,   cnt_d;
    logic           right_q, right_d;
    logic           sign_q,  sign_d;
    logic           sat_q,   sat_d;
    logic           err_q,   err_d;
    logic [3:0]     tqi_q,   tqi_d;
    logic [3:0]     tqf_q,   tqf_d;

    logic           legal;
    logic [W-1:0]   shr;
    logic           last_shift;
`ifdef FXP_RQ_ROUND_EN
    logic [W:0]     rnd;
`endif

    // Both formats must exactly fill the word and keep a sign bit.
    assign legal = (({1'b0, in_qi} + {1'b0, in_qf}) == W5) &&
                   (({1'b0, tgt_qi} + {1'b0, tgt_qf}) == W5) &&
                   (in_qi != 4'd0) && (tgt_qi != 4'd0);

    assign shr        = {data_q[W-1], data_q[W-1:1]};
    assign last_shift = (cnt_q == 4'd1);

`ifdef FXP_RQ_ROUND_EN
    // Guard bit is data_q[0] of the final right shift; add it in one extra
    // bit of headroom so a carry into the sign is detectable.
    assign rnd = {shr[W-1], shr} + {{W{1'b0}}, data_q[0]};
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        right_d = right_q;
        sign_d  = sign_q;
        sat_d   = sat_q;
        err_d   = err_q;
        tqi_d   = tqi_q;
        tqf_d   = tqf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d = in_data;
                    sign_d = in_data[W-1];
                    tqi_d  = tgt_qi;
                    tqf_d  = tgt_qf;
                    sat_d  = 1'b0;
                    err_d  = 1'b0;
                    if (!legal) begin
                        err_d   = 1'b1;
                        cnt_d   = 4'd0;
                        right_d = 1'b0;
                        state_d = S_DONE;
                    end else if (in_qf > tgt_qf) begin
                        right_d = 1'b1;
                        cnt_d   = in_qf - tgt_qf;
                        state_d = S_SHIFT;
                    end else begin
                        right_d = 1'b0;
                        cnt_d   = tgt_qf - in_qf;
                        state_d = (tgt_qf == in_qf) ? S_DONE : S_SHIFT;
                    end
                end
            end

            S_SHIFT: begin
                if (right_q) begin
                    data_d = shr;
                    cnt_d  = cnt_q - 4'd1;
                    if (last_shift) begin
                        state_d = S_DONE;
`ifdef FXP_RQ_ROUND_EN
                        if (rnd[W] != rnd[W-1]) begin
                            data_d = SAT_MAX;
                            sat_d  = 1'b1;
                        end else begin
                            data_d = rnd[W-1:0];
                        end
`endif
                    end
                end else begin
                    // A differing top pair means the next shift would lose
                    // the sign: clamp now instead of finishing the shifts.
                    if (data_q[W-1] != data_q[W-2]) begin
                        data_d  = sign_q ? SAT_MIN : SAT_MAX;
                        sat_d   = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = S_DONE;
                    end else begin
                        data_d = {data_q[W-2:0], 1'b0};
                        cnt_d  = cnt_q - 4'd1;
                        if (last_shift) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            right_q <= 1'b0;
            sign_q  <= 1'b0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
            tqi_q   <= '0;
            tqf_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            right_q <= right_d;
            sign_q  <= sign_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
            tqi_q   <= tqi_d;
            tqf_q   <= tqf_d;
        end
    end

    // in_ready is held low while reset is asserted so nothing is offered
    // a handshake that the register stage would discard.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign out_data  = data_q;
    assign out_qi    = tqi_q;
    assign out_qf    = tqf_q;
    assign out_sat   = sat_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_fxp_requant.sv
// -----------------------------------------------------------------------------
// tb_fxp_requant
//
// Directed vectors for fxp_requant (W=16). The driver pushes the expected
// result into a queue at each accepted handshake; an independent monitor
// pops and compares whenever out_valid is presented, and owns out_ready.
// -----------------------------------------------------------------------------
module tb_fxp_requant;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [3:0]    in_qi = '0;
    logic [3:0]    in_qf = '0;
    logic [3:0]    tgt_qi = '0;
    logic [3:0]    tgt_qf = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [3:0]    out_qi;
    logic [3:0]    out_qf;
    logic          out_sat;
    logic          out_err;

    typedef struct {
        logic [W-1:0] data;
        logic [3:0]   qi;
        logic [3:0]   qf;
        logic         sat;
        logic         err;
        int           lat;   // expected "T+lat" of first out_valid, <0 = skip
        int           hold;  // cycles to hold out_ready low
        int           acc;   // cycle number of the accepting edge
        string        name;
    } exp_t;

    exp_t exp_q[$];

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    fxp_requant #(.WORD_SIZE(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_qi     (in_qi),
        .in_qf     (in_qf),
        .tgt_qi    (tgt_qi),
        .tgt_qf    (tgt_qf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_qi    (out_qi),
        .out_qf    (out_qf),
        .out_sat   (out_sat),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Offer one word; push the expectation at the accepting edge unless
    // push==0 (used for the word that is aborted by reset).
    task automatic send(input string name, input logic [W-1:0] d,
                        input logic [3:0] iqi, input logic [3:0] iqf,
                        input logic [3:0] tqi, input logic [3:0] tqf,
                        input logic [W-1:0] ed, input logic es, input logic ee,
                        input int lat, input int hold, input bit push);
        exp_t e;
        int   waited;
        @(negedge clk);
        in_data  = d;
        in_qi    = iqi;
        in_qf    = iqf;
        tgt_qi   = tqi;
        tgt_qf   = tqf;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 200) begin
                nvec++;
                nmis++;
                $display("FAIL %s_accept: in_ready=0 after %0d cycles, expected 1", name, waited);
                in_valid = 1'b0;
                return;
            end
        end
        e.data = ed;  e.qi = tqi;  e.qf = tqf;
        e.sat = es;   e.err = ee;  e.lat = lat;
        e.hold = hold; e.acc = cyc + 1; e.name = name;
        @(posedge clk);
        if (push) exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare every presented result against the queue head.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (out_valid && !rst) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL unexpected_out: data=0x%0h, expected no result", out_data);
                end else begin
                    x = exp_q.pop_front();
                    chk({x.name, "_data"}, 32'(out_data), 32'(x.data));
                    chk({x.name, "_sat"},  32'(out_sat),  32'(x.sat));
                    chk({x.name, "_err"},  32'(out_err),  32'(x.err));
                    chk({x.name, "_qi"},   32'(out_qi),   32'(x.qi));
                    chk({x.name, "_qf"},   32'(out_qf),   32'(x.qf));
                    chk({x.name, "_inrdy"}, 32'(in_ready), 32'd0);
                    if (x.lat >= 0)
                        chk({x.name, "_lat"}, 32'(cyc - x.acc + 1), 32'(x.lat));
                    $display("txn %s: data=0x%04h sat=%0d err=%0d q=%0d.%0d", x.name,
                             out_data, out_sat, out_err, out_qi, out_qf);
                    for (int i = 0; i < x.hold; i++) begin
                        @(negedge clk);
                        chk({x.name, "_hold"},
                            {out_valid, in_ready, out_sat, out_err, 12'(out_data)},
                            {1'b1, 1'b0, x.sat, x.err, 12'(x.data)});
                    end
                end
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                chk("valid_drop", 32'(out_valid), 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            nvec++;
            nmis++;
            $display("FAIL %s_drain: %0d results outstanding, expected 0", name, exp_q.size());
        end
    endtask

    logic [W-1:0] r1, r2, r3;

    initial begin
`ifdef FXP_RQ_ROUND_EN
        r1 = 16'h0002; r2 = 16'hFFFF; r3 = 16'h4000;
`else
        r1 = 16'h0001; r2 = 16'hFFFE; r3 = 16'h3FFF;
`endif
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_flags", {out_qi, out_qf, 2'(out_sat), 2'(out_err)}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_inrdy", 32'(in_ready), 32'd1);

        //   name        data      iqi iqf tqi tqf  exp        sat   err  lat hold
        send("r4",     16'h0600, 4, 12, 8, 8,  16'h0060, 1'b0, 1'b0, 5,  0, 1'b1);
        send("l6",     16'h0100, 8, 8,  2, 14, 16'h4000, 1'b0, 1'b0, 7,  0, 1'b1);
        send("satpos", 16'h0300, 8, 8,  2, 14, 16'h7FFF, 1'b1, 1'b0, -1, 0, 1'b1);
        send("satneg", 16'hFD00, 8, 8,  2, 14, 16'h8000, 1'b1, 1'b0, -1, 0, 1'b1);
        send("rndpos", 16'h0018, 4, 12, 8, 8,  r1,       1'b0, 1'b0, 5,  0, 1'b1);
        send("rndneg", 16'hFFE8, 4, 12, 8, 8,  r2,       1'b0, 1'b0, 5,  0, 1'b1);
        send("errin",  16'h1234, 5, 12, 8, 8,  16'h1234, 1'b0, 1'b1, 1,  0, 1'b1);
        send("errtgt", 16'h5555, 8, 8,  9, 8,  16'h5555, 1'b0, 1'b1, 1,  0, 1'b1);
        send("same",   16'hABCD, 8, 8,  8, 8,  16'hABCD, 1'b0, 1'b0, 1,  0, 1'b1);
        send("minexact",16'hFF00,8, 8,  1, 15, 16'h8000, 1'b0, 1'b0, 8,  0, 1'b1);
        send("floorneg",16'h8000,2, 14, 15, 1, 16'hFFFC, 1'b0, 1'b0, 14, 0, 1'b1);
        send("r1max",  16'h7FFF, 1, 15, 2, 14, r3,       1'b0, 1'b0, 2,  0, 1'b1);
        send("hold",   16'h0123, 8, 8,  8, 8,  16'h0123, 1'b0, 1'b0, 1, 10, 1'b1);
        drain("main");

        // Reset pulse during SHIFT discards the word.
        send("abort",  16'h1000, 4, 12, 12, 4, 16'h0000, 1'b0, 1'b0, -1, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_inrdy", 32'(in_ready), 32'd1);
        chk("abort_data",  32'(out_data), 32'd0);
        repeat (20) @(negedge clk);
        chk("abort_quiet", 32'(out_valid), 32'd0);

        send("post",   16'h0600, 4, 12, 8, 8,  16'h0060, 1'b0, 1'b0, 5,  0, 1'b1);
        drain("post");
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
